// File: rtl/arm_pkg.sv
// Shared widths and types for the ARM pipeline datapath.
package arm_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_row.sv
// One architectural register: synchronous clear, write-enabled load.
module regfile_row
  import arm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_we,
  input  word_t i_d,
  output word_t o_q
);
  word_t r_q;

  // Reset has priority so a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset)     r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/wb_regfile.sv
// Write-back select plus 32x64 register file with two bypassed read ports; X31 reads zero.
module wb_regfile
  import arm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      RegWrite_WB,
  input  logic      MemToReg_WB,
  input  word_t     dataFromMem_WB,
  input  word_t     ALUResult_WB,
  input  reg_addr_t Rd_WB,
  input  reg_addr_t ReadReg1,
  input  reg_addr_t ReadReg2,
  output word_t     ReadData1,
  output word_t     ReadData2,
  output word_t     WriteData_WB
);
  word_t                 w_wdata;
  logic [NUM_REGS-1:0]   w_we;
  logic                  w_wr_live;
  word_t                 w_rows [NUM_REGS];

  assign w_wdata      = MemToReg_WB ? dataFromMem_WB : ALUResult_WB;
  assign WriteData_WB = w_wdata;
  assign w_wr_live    = RegWrite_WB && (Rd_WB != ZERO_REG);

  // X31 gets a constant-zero slot instead of storage so read muxes stay uniform.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    assign w_we[i] = w_wr_live && (Rd_WB == reg_addr_t'(i));
    if (i == int'(ZERO_REG)) begin : g_zero
      assign w_rows[i] = '0;
    end else begin : g_reg
      regfile_row u_row (
        .clk   (clk),
        .reset (reset),
        .i_we  (w_we[i]),
        .i_d   (w_wdata),
        .o_q   (w_rows[i])
      );
    end
  end

  // Bypass ignores reset: decode sees the in-flight value even if the edge discards it.
  function automatic word_t rd_port(input reg_addr_t addr, input word_t stored);
    if (addr == ZERO_REG)                    return '0;
    else if (w_wr_live && (Rd_WB == addr))   return w_wdata;
    else                                     return stored;
  endfunction

  assign ReadData1 = rd_port(ReadReg1, w_rows[ReadReg1]);
  assign ReadData2 = rd_port(ReadReg2, w_rows[ReadReg2]);
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench: stimulus queues expected read/write-back values, a negedge monitor checks them.
module tb_wb_regfile;
  import arm_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      RegWrite_WB, MemToReg_WB;
  word_t     dataFromMem_WB, ALUResult_WB;
  reg_addr_t Rd_WB, ReadReg1, ReadReg2;
  word_t     ReadData1, ReadData2, WriteData_WB;

  wb_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite_WB    (RegWrite_WB),
    .MemToReg_WB    (MemToReg_WB),
    .dataFromMem_WB (dataFromMem_WB),
    .ALUResult_WB   (ALUResult_WB),
    .Rd_WB          (Rd_WB),
    .ReadReg1       (ReadReg1),
    .ReadReg2       (ReadReg2),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .WriteData_WB   (WriteData_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    word_t e1;
    word_t e2;
    word_t ew;
    bit    chk_w;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic cmp(input string name, input string what, input word_t got, input word_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s %s got %h want %h", name, what, got, want);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "ReadData1", ReadData1, e.e1);
      cmp(e.name, "ReadData2", ReadData2, e.e2);
      if (e.chk_w) cmp(e.name, "WriteData_WB", WriteData_WB, e.ew);
    end
  end

  // Drive one cycle of inputs; chk=0 issues the cycle without queuing an expectation.
  task automatic cyc(input string name, input bit rst, input bit rw, input bit m2r,
                     input word_t mem, input word_t alu, input reg_addr_t rd,
                     input reg_addr_t r1, input reg_addr_t r2,
                     input word_t e1, input word_t e2, input word_t ew,
                     input bit chk_w, input bit chk);
    exp_t e;
    reset = rst; RegWrite_WB = rw; MemToReg_WB = m2r;
    dataFromMem_WB = mem; ALUResult_WB = alu; Rd_WB = rd;
    ReadReg1 = r1; ReadReg2 = r2;
    if (chk) begin
      e.name = name; e.e1 = e1; e.e2 = e2; e.ew = ew; e.chk_w = chk_w;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  localparam word_t Z = '0;

  initial begin
    @(posedge clk); #1;
    cyc("reset", 1, 0, 0, Z, Z, 5'd0, 5'd0, 5'd0, Z, Z, Z, 0, 0);
    cyc("reset", 1, 0, 0, Z, Z, 5'd0, 5'd0, 5'd0, Z, Z, Z, 0, 0);

    // 1: every index reads zero after reset, both ports
    for (int i = 0; i < 32; i++)
      cyc("rst_read", 0, 0, 0, Z, Z, 5'd0, reg_addr_t'(i), reg_addr_t'(31 - i), Z, Z, Z, 0, 1);

    // 2: ALU write with same-cycle bypass, then stored value
    cyc("alu_bypass", 0, 1, 0, 64'h5555, 64'hDEAD_BEEF, 5'd5, 5'd5, 5'd0,
        64'hDEAD_BEEF, Z, 64'hDEAD_BEEF, 1, 1);
    cyc("alu_stored", 0, 0, 0, Z, Z, 5'd5, 5'd5, 5'd5,
        64'hDEAD_BEEF, 64'hDEAD_BEEF, Z, 1, 1);

    // 3: memory data selected over ALU result
    cyc("mem_sel", 0, 1, 1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 5'd7, 5'd5,
        64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 1, 1);
    cyc("mem_stored", 0, 0, 1, Z, 64'h99, 5'd7, 5'd5, 5'd7,
        64'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0, Z, 0, 1);

    // 4: XZR ignores writes and never bypasses
    cyc("xzr_write", 0, 1, 0, Z, 64'hFF, 5'd31, 5'd31, 5'd31, Z, Z, 64'hFF, 1, 1);
    cyc("xzr_after", 0, 0, 0, Z, Z, 5'd31, 5'd31, 5'd7, Z, 64'h1234_5678_9ABC_DEF0, Z, 0, 1);

    // boundary rows 0 and 30
    cyc("x0_write", 0, 1, 0, 64'hBAD, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd1, 5'd0,
        Z, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 1);
    cyc("x30_write", 0, 1, 1, 64'h8000_0000_0000_0001, Z, 5'd30, 5'd0, 5'd30,
        64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1, 1);
    cyc("x30_stored", 0, 0, 0, Z, Z, 5'd0, 5'd30, 5'd29,
        64'h8000_0000_0000_0001, Z, Z, 0, 1);

    // 5: reset wins over a concurrent write; bypass still visible during that cycle
    cyc("x3_write", 0, 1, 0, Z, 64'hA5, 5'd3, 5'd3, 5'd0, 64'hA5, 64'h0123_4567_89AB_CDEF, 64'hA5, 1, 1);
    cyc("x3_stored", 0, 0, 0, Z, Z, 5'd3, 5'd3, 5'd5, 64'hA5, 64'hDEAD_BEEF, Z, 0, 1);
    cyc("rst_bypass", 1, 1, 0, Z, 64'h77, 5'd3, 5'd3, 5'd5, 64'h77, 64'hDEAD_BEEF, 64'h77, 1, 1);
    cyc("rst_cleared", 0, 0, 0, Z, 64'h77, 5'd3, 5'd3, 5'd7, Z, Z, Z, 0, 1);
    cyc("rst_cleared2", 0, 0, 0, Z, Z, 5'd3, 5'd30, 5'd0, Z, Z, Z, 0, 1);

    // 6: dual-port bypass vs. disabled write
    cyc("x10_init", 0, 1, 0, Z, 64'h11, 5'd10, 5'd0, 5'd0, Z, Z, 64'h11, 1, 1);
    cyc("x10_nowrite", 0, 0, 0, Z, 64'h42, 5'd10, 5'd10, 5'd10, 64'h11, 64'h11, 64'h42, 1, 1);
    cyc("x10_dual_byp", 0, 1, 0, Z, 64'h42, 5'd10, 5'd10, 5'd10, 64'h42, 64'h42, 64'h42, 1, 1);
    cyc("x10_stored", 0, 0, 0, Z, Z, 5'd10, 5'd10, 5'd10, 64'h42, 64'h42, Z, 0, 1);

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
